imem_boot_loader: RTL
=====================

# imem_boot_loader

Boot-time program loader for the instruction memory of the single-cycle RISC-V core. It receives a length-prefixed, checksummed byte stream, assembles little-endian 32-bit words, and writes them into IMEM through a word-aligned write port. It holds the core in reset until a load completes with a valid checksum, so the PC/fetch path never sees a partially loaded program.

## Interface
Parameters:
- PC_WIDTH_LENGTH, 32, width of mem_addr (byte address, same space as PC)
- MEM_DEPTH, 1<<18, IMEM depth in 32-bit words; upper bound on accepted word count
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-byte aligned

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle; transfer = rx_valid & rx_ready
- mem_we  out  1  one-cycle IMEM word write strobe
- mem_addr  out  PC_WIDTH_LENGTH  byte address of write, always [1:0]=2'b00
- mem_wdata  out  32  word to write
- core_rst_n  out  1  active-low reset to the core; low until a successful load
- done  out  1  load completed, checksum good
- error  out  1  load aborted (oversize length or checksum mismatch)
- words_loaded  out  19  count of words written in the current/last load

## Operation
- States: IDLE, LEN, DATA, CHECK, DONE, ERR.
- IDLE: rx_ready=0; start -> LEN; clears byte counter, word index, checksum, done, error, words_loaded; core_rst_n=0.
- LEN: rx_ready=1; accepts 4 bytes, little-endian, into 32-bit len. After 4th byte: len > MEM_DEPTH -> ERR; len==0 -> CHECK; else DATA.
- DATA: rx_ready=1; accepts bytes little-endian into word buffer (byte 0 -> bits [7:0]). Every accepted byte XORs into 8-bit checksum. After the 4th byte of a word: issue write, increment word index; when index reaches len -> CHECK.
- CHECK: rx_ready=1; accepts one byte; equal to running checksum -> DONE, else ERR. Length bytes are not covered by the checksum.
- DONE: rx_ready=0, done=1, core_rst_n=1. start -> LEN (core_rst_n drops to 0 the same edge).
- ERR: rx_ready=0, error=1, core_rst_n=0. start -> LEN.
- start in LEN/DATA/CHECK is ignored. rx_valid while rx_ready=0 is ignored (byte not consumed).
- Write address = BASE_ADDR + 4*index; index width 19 bits, never wraps since len ≤ MEM_DEPTH.
- Words already written before an ERR remain in IMEM; the loader does not erase them.

## Timing
- Reset (async, rst_n low): state=IDLE, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_rst_n=0, done=0, error=0, words_loaded=0. Outputs take reset values immediately, not at the next edge.
- Reset mid-load: abort unconditionally; no further mem_we; next load requires start.
- All outputs are registered. rx_ready reflects the current state.
- mem_we is high for exactly the one cycle after the edge that accepted the 4th byte of a word; mem_addr/mem_wdata are valid that same cycle; words_loaded updates on that same edge.
- No back-pressure on writes: a byte accepted during the mem_we cycle is legal; back-to-back bytes sustain one word per 4 cycles.
- Transition to DONE/ERR occurs on the edge accepting the checksum byte (or the 4th length byte for oversize); done/error/core_rst_n change that edge.
- Minimum load of N words from start: 1 + 4 + 4N + 1 cycles with rx_valid held high.

## Test plan
- start; bytes 02 00 00 00 | 13 00 00 00 | 93 00 A0 00 | 20 -> writes (addr 0x0, 0x00000013) then (addr 0x4, 0x00A00093), words_loaded=2, done=1, core_rst_n=1, error=0.
- Same stream with checksum 21 -> both writes occur, error=1, done=0, core_rst_n stays 0.
- Length bytes 01 00 04 00 (0x40001 > MEM_DEPTH) -> ERR right after the 4th length byte, no mem_we ever, rx_ready=0.
- Length 00 00 00 00, checksum 00 -> DONE, no mem_we, words_loaded=0; same with checksum 01 -> ERR.
- Random rx_valid gaps plus start pulses during DATA -> identical writes to the gap-free case, start ignored; assert rst_n low after the first write -> all outputs at reset values immediately, no further writes.
- After DONE, start and reload one word DEADBEEF (bytes EF BE AD DE, checksum 0x22) with BASE_ADDR=0x100 -> core_rst_n low during load, write at 0x100 data 0xDEADBEEF, done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes little-endian
// words into IMEM and holds the core in reset until a load finishes with a good checksum.
module imem_boot_loader #(
  parameter int          PC_WIDTH_LENGTH = 32,
  parameter int          MEM_DEPTH       = 1 << 18,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       mem_we,
  output logic [PC_WIDTH_LENGTH-1:0] mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       core_rst_n,
  output logic                       done,
  output logic                       error,
  output logic [18:0]                words_loaded
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are both high;
  // rx_valid while rx_ready is low leaves the byte with the sender.

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [PC_WIDTH_LENGTH-1:0] BASE_W  = PC_WIDTH_LENGTH'(BASE_ADDR);
  localparam logic [31:0]                MAX_LEN = 32'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q;
  logic [23:0] sh_q;
  logic [31:0] len_q;
  logic [18:0] idx_q;
  logic [7:0]  csum_q;

  logic        xfer;
  logic        last_byte;
  logic        start_ok;
  logic [31:0] full_word;
  logic [18:0] idx_nxt;

  assign xfer      = rx_valid & rx_ready;
  assign last_byte = (bcnt_q == 2'd3);
  assign full_word = {rx_data, sh_q};
  assign idx_nxt   = idx_q + 19'd1;
  assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer && last_byte) begin
          if (full_word > MAX_LEN)     state_d = S_ERR;
          else if (full_word == 32'd0) state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && last_byte && ({13'd0, idx_nxt} == len_q)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the deciding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      core_rst_n   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_W;
      mem_wdata    <= 32'd0;
      words_loaded <= 19'd0;
      bcnt_q       <= 2'd0;
      sh_q         <= 24'd0;
      len_q        <= 32'd0;
      idx_q        <= 19'd0;
      csum_q       <= 8'd0;
    end else begin
      rx_ready   <= (state_d == S_LEN) | (state_d == S_DATA) | (state_d == S_CHECK);
      done       <= (state_d == S_DONE);
      error      <= (state_d == S_ERR);
      core_rst_n <= (state_d == S_DONE);
      mem_we     <= 1'b0;
      if (start_ok) begin
        bcnt_q       <= 2'd0;
        idx_q        <= 19'd0;
        csum_q       <= 8'd0;
        words_loaded <= 19'd0;
      end else if (xfer && ((state_q == S_LEN) || (state_q == S_DATA))) begin
        bcnt_q <= bcnt_q + 2'd1;
        sh_q   <= {rx_data, sh_q[23:8]};
        if (state_q == S_LEN) begin
          if (last_byte) len_q <= full_word;
        end else begin
          csum_q <= csum_q ^ rx_data;
          if (last_byte) begin
            mem_we       <= 1'b1;
            mem_addr     <= BASE_W + PC_WIDTH_LENGTH'({idx_q, 2'b00});
            mem_wdata    <= full_word;
            idx_q        <= idx_nxt;
            words_loaded <= idx_nxt;
          end
        end
      end
    end
  end

endmodule
